pipe_stage_reg: RTL and testbench

Parametrised, elastic pipeline register stage for the processor datapath; the next generation of the fixed-field inter-stage latches. Carries a WIDTH-bit packed payload between two stages using a valid/ready handshake, with an optional two-entry skid buffer, synchronous flush that inserts a bubble, and a saturating stall-cycle counter. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB; the hazard unit drives flush.

---
 rtl/pipe_pkg.sv | 49 ++++
 rtl/sat_counter.sv | 28 ++
 rtl/pipe_stage_reg.sv | 140 ++++++++++++++
 tb/tb_pipe_stage_reg.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared types for the elastic inter-stage pipeline registers.
//   pipe_state_t : occupancy state of one pipe_stage_reg instance
//   ifid_t .. memwb_t : packed stage payloads; $bits() of these sets the
//                       WIDTH parameter of the instance between two stages.
// -----------------------------------------------------------------------------
package pipe_pkg;

  // Encoding equals the number of held entries, so it doubles as occupancy.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [3:0]  alu_op;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } idex_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] store_val;
    logic [4:0]  rd;
    logic        mem_rd;
    logic        mem_wr;
    logic        reg_wr;
  } exmem_t;

  typedef struct packed {
    logic [31:0] wb_val;
    logic [4:0]  rd;
    logic        reg_wr;
  } memwb_t;

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at its all-ones value.
//   CLK   : clock, rising edge
//   RST   : synchronous active-high clear
//   inc   : count this cycle
//   count : current value, 0 .. 2^W-1
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int W = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state uses non-blocking assignment so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Elastic valid/ready pipeline register between two datapath stages, with an
// optional two-entry skid buffer, bubble-inserting flush and a saturating
// stall-cycle counter.
//   CLK, RST            : clock / synchronous active-high reset
//   flush               : drop all held entries and any incoming payload
//   in_valid/in_ready   : upstream handshake, in_data payload
//   out_valid/out_ready : downstream handshake, out_data payload ('0 if empty)
//   occupancy           : entries held (0..2)
//   stall_cnt           : cycles with out_valid & ~out_ready, saturating
// Parameters: WIDTH payload bits, SKID (1 = registered in_ready, two entries;
// 0 = one entry, combinational in_ready), CNT_W stall counter width.
// -----------------------------------------------------------------------------
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  pipe_state_t      r_state, w_state_nxt;
  logic [WIDTH-1:0] r_main, w_main_nxt;
  logic [WIDTH-1:0] r_skid, w_skid_nxt;
  logic             w_in_accept;
  logic             w_out_xfer;
  logic             w_stall;

  // Payload registers are cleared whenever their entry goes invalid, so the
  // main register can drive out_data directly and still read '0 when empty.
  assign out_valid = (r_state != EMPTY);
  assign out_data  = r_main;
  assign occupancy = r_state;

  // A payload offered during flush is dropped even if in_ready is high.
  assign w_in_accept = in_valid & in_ready & ~flush;
  assign w_out_xfer  = out_valid & out_ready;
  assign w_stall     = out_valid & ~out_ready;

  generate
    if (SKID != 0) begin : g_skid
      // in_ready decodes state only, cutting the out_ready -> in_ready path.
      assign in_ready = (r_state != TWO);

      always_ff @(posedge CLK) begin
        if (RST) begin
          r_skid <= '0;
        end else begin
          r_skid <= w_skid_nxt;
        end
      end
    end else begin : g_noskid
      assign in_ready = out_ready | ~out_valid;
      assign r_skid   = '0;
    end
  endgenerate

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    w_state_nxt = r_state;
    w_main_nxt  = r_main;
    w_skid_nxt  = r_skid;

    if (flush) begin
      w_state_nxt = EMPTY;
      w_main_nxt  = '0;
      w_skid_nxt  = '0;
    end else begin
      case (r_state)
        EMPTY: begin
          if (w_in_accept) begin
            w_state_nxt = ONE;
            w_main_nxt  = in_data;
          end
        end
        ONE: begin
          if (w_in_accept && w_out_xfer) begin
            w_main_nxt = in_data;
          end else if (w_in_accept) begin
            // Without a skid buffer in_ready equals out_ready here, so an
            // accept always coincides with a drain and this branch is dead.
            w_state_nxt = TWO;
            w_skid_nxt  = in_data;
          end else if (w_out_xfer) begin
            w_state_nxt = EMPTY;
            w_main_nxt  = '0;
          end
        end
        TWO: begin
          if (w_out_xfer) begin
            w_state_nxt = ONE;
            w_main_nxt  = r_skid;
            w_skid_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = EMPTY;
          w_main_nxt  = '0;
          w_skid_nxt  = '0;
        end
      endcase
    end
  end

  // NOTE: the payload registers are reset along with the state because
  // out_data is taken straight from r_main and must read '0 after reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= EMPTY;
      r_main  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_main  <= w_main_nxt;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (w_stall),
    .count(stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_stage_reg
// Three instances driven side by side:
//   u0 : SKID=1, CNT_W=16    u1 : SKID=0, CNT_W=16    u2 : SKID=1, CNT_W=3
// Each upstream source is a queue of words; a word leaves its source when the
// DUT takes it (or a flush/reset swallows it). The reference model is a
// bounded FIFO of accepted words plus a saturating stall count.
// -----------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam bit [2:0] SKIDS = 3'b101;

  logic clk;

  // Stimulus, one bit/element per instance.
  logic [2:0]       rst, flush, in_valid, out_ready;
  logic [2:0][31:0] in_data;

  // Raw DUT outputs.
  logic        ir0, ir1, ir2, ov0, ov1, ov2;
  logic [31:0] od0, od1, od2;
  logic [1:0]  oc0, oc1, oc2;
  logic [15:0] sc0, sc1;
  logic [2:0]  sc2;

  // DUT outputs gathered for indexed access.
  logic [2:0]       in_ready_a, out_valid_a;
  logic [2:0][31:0] out_data_a;
  logic [2:0][1:0]  occ_a;
  logic [2:0][15:0] stall_a;

  always_comb begin
    in_ready_a  = {ir2, ir1, ir0};
    out_valid_a = {ov2, ov1, ov0};
    out_data_a  = {od2, od1, od0};
    occ_a       = {oc2, oc1, oc0};
    stall_a     = {{13'd0, sc2}, sc1, sc0};
  end

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(16)) u0 (
    .CLK(clk), .RST(rst[0]), .flush(flush[0]),
    .in_valid(in_valid[0]), .in_ready(ir0), .in_data(in_data[0]),
    .out_valid(ov0), .out_ready(out_ready[0]), .out_data(od0),
    .occupancy(oc0), .stall_cnt(sc0)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(0), .CNT_W(16)) u1 (
    .CLK(clk), .RST(rst[1]), .flush(flush[1]),
    .in_valid(in_valid[1]), .in_ready(ir1), .in_data(in_data[1]),
    .out_valid(ov1), .out_ready(out_ready[1]), .out_data(od1),
    .occupancy(oc1), .stall_cnt(sc1)
  );

  pipe_stage_reg #(.WIDTH(32), .SKID(1), .CNT_W(3)) u2 (
    .CLK(clk), .RST(rst[2]), .flush(flush[2]),
    .in_valid(in_valid[2]), .in_ready(ir2), .in_data(in_data[2]),
    .out_valid(ov2), .out_ready(out_ready[2]), .out_data(od2),
    .occupancy(oc2), .stall_cnt(sc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned stall_max(input int i);
    return (i == 2) ? 32'd7 : 32'd65535;
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard / reference model. Outputs are compared at the falling edge,
  // then the consequences of this cycle's inputs are applied to the model.
  // ---------------------------------------------------------------------------
  logic [31:0] sb[3][$];
  int unsigned stall_m[3];
  bit          armed[3];

  always @(negedge clk) begin
    int unsigned sz;
    bit          exp_rdy;
    for (int i = 0; i < 3; i++) begin
      sz      = sb[i].size();
      exp_rdy = SKIDS[i] ? (sz < 2) : ((sz == 0) || out_ready[i]);
      if (armed[i]) begin
        check($sformatf("u%0d out_valid", i), {31'd0, out_valid_a[i]}, {31'd0, sz > 0});
        check($sformatf("u%0d out_data", i), out_data_a[i], (sz > 0) ? sb[i][0] : 32'h0);
        check($sformatf("u%0d in_ready", i), {31'd0, in_ready_a[i]}, {31'd0, exp_rdy});
        check($sformatf("u%0d occupancy", i), {30'd0, occ_a[i]}, sz);
        check($sformatf("u%0d stall_cnt", i), {16'd0, stall_a[i]}, stall_m[i]);
      end
      if (rst[i]) begin
        sb[i].delete();
        stall_m[i] = 0;
        armed[i]   = 1'b1;
      end else if (armed[i]) begin
        if (sz > 0 && !out_ready[i] && stall_m[i] < stall_max(i)) stall_m[i]++;
        if (sz > 0 && out_ready[i]) void'(sb[i].pop_front());
        if (flush[i]) sb[i].delete();
        else if (in_valid[i] && exp_rdy) sb[i].push_back(in_data[i]);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Upstream sources and cycle stepping.
  // ---------------------------------------------------------------------------
  logic [31:0] src[3][$];
  logic [2:0]  gate;

  task automatic apply();
    for (int i = 0; i < 3; i++) begin
      in_valid[i] = gate[i] && (src[i].size() > 0);
      in_data[i]  = (src[i].size() > 0) ? src[i][0] : 32'h0;
    end
  endtask

  task automatic tick();
    apply();
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      if (in_valid[i] && (in_ready_a[i] === 1'b1 || flush[i] || rst[i]))
        void'(src[i].pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_all(input logic [31:0] w);
    for (int i = 0; i < 3; i++) src[i].push_back(w);
  endtask

  task automatic clear_src();
    for (int i = 0; i < 3; i++) src[i].delete();
  endtask

  initial begin
    rst       = '1;
    flush     = '0;
    out_ready = '0;
    gate      = '1;
    in_valid  = '0;
    in_data   = '0;

    // Reset held with a live payload offered upstream.
    repeat (3) push_all(32'hDEAD_BEEF);
    repeat (3) tick();
    rst = '0;
    clear_src();
    tick();

    // Streaming 1..8 with the sink always ready.
    out_ready = '1;
    for (int w = 1; w <= 8; w++) push_all(32'(w));
    repeat (12) tick();

    // Backpressure: A, B, C offered while the sink stalls, then released.
    out_ready = '0;
    push_all(32'hA0A0_A0A0);
    push_all(32'hB0B0_B0B0);
    push_all(32'hC0C0_C0C0);
    repeat (5) tick();
    out_ready = '1;
    repeat (6) tick();

    // Flush with two entries held and a new word offered in the flush cycle.
    out_ready = '0;
    push_all(32'hA1A1_A1A1);
    push_all(32'hB1B1_B1B1);
    repeat (2) tick();
    push_all(32'hC1C1_C1C1);
    flush = '1;
    tick();
    flush     = '0;
    out_ready = '1;
    repeat (4) tick();

    // Saturation: long stall, flush must not clear the count, reset must.
    rst = '1;
    tick();
    rst = '0;
    push_all(32'h5A5A_5A5A);
    out_ready = '0;
    repeat (12) tick();
    flush = '1;
    tick();
    flush = '0;
    repeat (2) tick();
    rst = '1;
    tick();
    rst = '0;
    tick();

    // Randomised traffic: bursty source, random sink, occasional flush/reset.
    repeat (600) begin
      for (int i = 0; i < 3; i++) begin
        if (src[i].size() < 3 && $urandom_range(0, 1) == 1) src[i].push_back($urandom);
        gate[i]      = ($urandom_range(0, 3) != 0);
        out_ready[i] = ($urandom_range(0, 2) != 0);
        flush[i]     = ($urandom_range(0, 24) == 0);
        rst[i]       = ($urandom_range(0, 199) == 0);
      end
      tick();
    end

    // Drain.
    gate      = '0;
    flush     = '0;
    rst       = '0;
    out_ready = '1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
